// File: rtl/program_sequencer.sv
// Program sequencer: holds a small instruction memory and issues one instruction at a time
// to the executor, advancing on Done until HALT, end of memory or a Done timeout.
module program_sequencer #(
  parameter int P       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         LoadEnable,
  input  logic [P-1:0] LoadAddress,
  input  logic [19:0]  LoadData,
  input  logic         Start,
  output logic [19:0]  OpCode,
  input  logic         Done,
  output logic         Busy,
  output logic         Halted,
  output logic         Timeout,
  output logic [P-1:0] ProgramCounter,
  output logic [15:0]  InstrCount
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
  localparam logic [P-1:0]      PC_LAST    = {P{1'b1}};
  localparam logic [3:0]        OP_HALT    = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_END   = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [P-1:0]        pc_r;
  logic [15:0]         icnt_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [WAIT_W-1:0]   wait_inc_s;
  logic [19:0]         ir_r;
  logic [19:0]         mem_r [0:(1<<P)-1];
  logic                load_ok_s;

  assign wait_inc_s     = wait_cnt_r + WAIT_W'(1);
  assign load_ok_s      = (state_r == ST_IDLE) || (state_r == ST_END) || (state_r == ST_ABORT);
  assign ProgramCounter = pc_r;
  assign InstrCount     = icnt_r;

  // Program memory write port; contents survive reset
  always_ff @(posedge Clock) begin
    if (LoadEnable && load_ok_s) begin
      mem_r[LoadAddress] <= LoadData;
    end
  end

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_END, ST_ABORT: begin
        if (Start) begin
          state_s = ST_FETCH;
        end else begin
          state_s = state_r;
        end
      end
      ST_FETCH: begin
        if (mem_r[pc_r][19:16] == OP_HALT) begin
          state_s = ST_END;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (Done) begin
          if (pc_r == PC_LAST) begin
            state_s = ST_END;
          end else begin
            state_s = ST_FETCH;
          end
        end else if (wait_inc_s == WAIT_LIMIT) begin
          state_s = ST_ABORT;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Datapath registers: PC, completed-instruction count, wait counter, instruction register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_r       <= {P{1'b0}};
      icnt_r     <= 16'd0;
      wait_cnt_r <= {WAIT_W{1'b0}};
      ir_r       <= 20'h0_00_00;
    end else begin
      case (state_r)
        ST_IDLE, ST_END, ST_ABORT: begin
          if (Start) begin
            pc_r   <= {P{1'b0}};
            icnt_r <= 16'd0;
          end
        end
        ST_FETCH: ir_r <= mem_r[pc_r];
        ST_ISSUE: wait_cnt_r <= {WAIT_W{1'b0}};
        ST_WAIT: begin
          if (Done) begin
            if (icnt_r != 16'hFFFF) begin
              icnt_r <= icnt_r + 16'd1;
            end
            // The last address ends the run in place rather than wrapping to 0
            if (pc_r != PC_LAST) begin
              pc_r <= pc_r + {{(P-1){1'b0}}, 1'b1};
            end
          end else begin
            wait_cnt_r <= wait_inc_s;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode; Done masks OpCode in WAIT so the executor never re-samples a finished op
  always_comb begin
    Busy    = (state_r == ST_FETCH) || (state_r == ST_ISSUE) || (state_r == ST_WAIT);
    Halted  = (state_r == ST_END);
    Timeout = (state_r == ST_ABORT);
    OpCode  = 20'h0_00_00;
    case (state_r)
      ST_ISSUE: OpCode = ir_r;
      ST_WAIT: begin
        if (Done) begin
          OpCode = 20'h0_00_00;
        end else begin
          OpCode = ir_r;
        end
      end
      default: OpCode = 20'h0_00_00;
    endcase
  end

endmodule
